// File: rtl/rs_pkg.sv
// Shared types and limits for the register slice chain (register_slice_chain, rs_stage).
package rs_pkg;

  typedef enum logic [1:0] {
    RS_FWD  = 2'd0,
    RS_BWD  = 2'd1,
    RS_FULL = 2'd2
  } rs_mode_e;

  localparam int RS_MAX_DEPTH = 16;

endpackage

// File: rtl/rs_stage.sv
// One register slice stage: forward (registered valid/data), backward (registered ready,
// one skid entry) or full (two entries, everything registered).
module rs_stage
  import rs_pkg::*;
#(
  parameter int       DATA_W = 32,
  parameter rs_mode_e MODE   = RS_FULL
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  // Handshake: a beat moves across a port on a rising edge where valid and ready are
  // both high; valid never depends on ready being high first, and data is held while valid
  // and not ready.
  if (MODE == RS_FWD) begin : g_fwd
    logic              full_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
      if (clear) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else if (in_ready) begin
        full_q <= in_valid;
        if (in_valid) data_q <= in_data;
      end
    end

    assign in_ready  = ~full_q | out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;
    assign occ       = {1'b0, full_q};

  end else if (MODE == RS_BWD) begin : g_bwd
    logic              skid_q;
    logic [DATA_W-1:0] skid_data_q;

    always_ff @(posedge clk) begin
      if (clear) begin
        skid_q      <= 1'b0;
        skid_data_q <= '0;
      end else if (skid_q) begin
        if (out_ready) skid_q <= 1'b0;
      end else if (in_valid && !out_ready) begin
        skid_q      <= 1'b1;
        skid_data_q <= in_data;
      end
    end

    // Pass-through path is masked when idle so an empty chain shows zero data.
    assign in_ready  = ~skid_q;
    assign out_valid = skid_q | in_valid;
    assign out_data  = skid_q ? skid_data_q : (in_valid ? in_data : '0);
    assign occ       = {1'b0, skid_q};

  end else begin : g_full
    logic              out_valid_q;
    logic              skid_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] skid_data_q;

    always_ff @(posedge clk) begin
      if (clear) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
        out_data_q   <= '0;
        skid_data_q  <= '0;
      end else if (!out_valid_q || out_ready) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_data_q   <= skid_data_q;
          skid_valid_q <= 1'b0;
        end else begin
          out_valid_q <= in_valid;
          if (in_valid) out_data_q <= in_data;
        end
      end else if (in_valid && !skid_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data;
      end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
  end

endmodule

// File: rtl/register_slice_chain.sv
// DEPTH cascaded rs_stage slices with flush and a live occupancy count.
// Optional RS_CHAIN_STATS_EN adds xfer_cnt / stall_cnt handshake statistics.
module register_slice_chain
  import rs_pkg::*;
#(
  parameter int       DATA_W = 32,
  parameter int       DEPTH  = 2,
  parameter rs_mode_e MODE   = RS_FULL
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DATA_W-1:0]                i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_W-1:0]                o_data,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
`ifdef RS_CHAIN_STATS_EN
  ,
  output logic [31:0]                      xfer_cnt,
  output logic [31:0]                      stall_cnt
`endif
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic              kill;
  logic [DEPTH:0]    v;
  logic [DEPTH:0]    r;
  logic [DATA_W-1:0] d   [DEPTH+1];
  logic [1:0]        occ [DEPTH];
  logic [OCC_W-1:0]  occ_sum;

  // rst and flush both empty every stage and block the external handshakes that cycle.
  assign kill     = rst | flush;
  assign v[0]     = i_valid & ~kill;
  assign d[0]     = i_data;
  assign r[DEPTH] = i_ready & ~kill;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    rs_stage #(
      .DATA_W (DATA_W),
      .MODE   (MODE)
    ) u_stage (
      .clk       (clk),
      .clear     (kill),
      .in_valid  (v[s]),
      .in_ready  (r[s]),
      .in_data   (d[s]),
      .out_valid (v[s+1]),
      .out_ready (r[s+1]),
      .out_data  (d[s+1]),
      .occ       (occ[s])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < DEPTH; k++) occ_sum = occ_sum + OCC_W'(occ[k]);
  end

  assign o_valid   = v[DEPTH] & ~kill;
  assign o_ready   = r[0] & ~kill;
  assign o_data    = d[DEPTH];
  assign occupancy = occ_sum;

`ifdef RS_CHAIN_STATS_EN
  // Only rst clears the statistics; flush just suppresses handshakes for a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (o_valid && i_ready)  xfer_cnt  <= xfer_cnt + 32'd1;
      if (o_valid && !i_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_slice_chain.sv
// Scoreboard bench for register_slice_chain across RS_FULL, RS_BWD and RS_FWD builds.
module tb_register_slice_chain;
  import rs_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // instance a: RS_FULL, DEPTH 3
  logic a_valid, a_ready, a_flush, a_o_ready, a_o_valid;
  logic [31:0] a_data, a_o_data;
  logic [2:0]  a_occ;
  // instance b: RS_FULL, DEPTH 2
  logic b_valid, b_ready, b_flush, b_o_ready, b_o_valid;
  logic [31:0] b_data, b_o_data;
  logic [2:0]  b_occ;
  // instance c: RS_BWD, DEPTH 1
  logic c_valid, c_ready, c_flush, c_o_ready, c_o_valid;
  logic [31:0] c_data, c_o_data;
  logic [1:0]  c_occ;
  // instance d: RS_FWD, DEPTH 4
  logic d_valid, d_ready, d_flush, d_o_ready, d_o_valid;
  logic [31:0] d_data, d_o_data;
  logic [3:0]  d_occ;
`ifdef RS_CHAIN_STATS_EN
  logic [31:0] a_xfer, a_stall, b_xfer, b_stall, c_xfer, c_stall, d_xfer, d_stall;
`endif

  register_slice_chain #(.DATA_W(32), .DEPTH(3), .MODE(RS_FULL)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .i_valid(a_valid), .o_ready(a_o_ready),
    .i_data(a_data), .o_valid(a_o_valid), .i_ready(a_ready), .o_data(a_o_data),
    .occupancy(a_occ)
`ifdef RS_CHAIN_STATS_EN
    , .xfer_cnt(a_xfer), .stall_cnt(a_stall)
`endif
  );
  register_slice_chain #(.DATA_W(32), .DEPTH(2), .MODE(RS_FULL)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .i_valid(b_valid), .o_ready(b_o_ready),
    .i_data(b_data), .o_valid(b_o_valid), .i_ready(b_ready), .o_data(b_o_data),
    .occupancy(b_occ)
`ifdef RS_CHAIN_STATS_EN
    , .xfer_cnt(b_xfer), .stall_cnt(b_stall)
`endif
  );
  register_slice_chain #(.DATA_W(32), .DEPTH(1), .MODE(RS_BWD)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .i_valid(c_valid), .o_ready(c_o_ready),
    .i_data(c_data), .o_valid(c_o_valid), .i_ready(c_ready), .o_data(c_o_data),
    .occupancy(c_occ)
`ifdef RS_CHAIN_STATS_EN
    , .xfer_cnt(c_xfer), .stall_cnt(c_stall)
`endif
  );
  register_slice_chain #(.DATA_W(32), .DEPTH(4), .MODE(RS_FWD)) u_d (
    .clk(clk), .rst(rst), .flush(d_flush), .i_valid(d_valid), .o_ready(d_o_ready),
    .i_data(d_data), .o_valid(d_o_valid), .i_ready(d_ready), .o_data(d_o_data),
    .occupancy(d_occ)
`ifdef RS_CHAIN_STATS_EN
    , .xfer_cnt(d_xfer), .stall_cnt(d_stall)
`endif
  );

  // scoreboard queues and delivered-beat counts
  logic [31:0] a_q[$], b_q[$], c_q[$], d_q[$];
  int a_t[$];
  int a_n = 0, b_n = 0, c_n = 0, d_n = 0;

  always @(negedge clk) begin
    if (a_valid && a_o_ready) begin a_q.push_back(a_data); a_t.push_back(cyc); end
    if (a_o_valid && a_ready) begin
      a_n++;
      if (a_q.size() == 0) chk("a_spurious_beat", 64'd1, 64'd0);
      else begin
        chk("a_data", a_o_data, a_q.pop_front());
        chk("a_latency", cyc - a_t.pop_front(), 64'd3);
      end
    end
  end

  always @(negedge clk) begin
    if (b_valid && b_o_ready) b_q.push_back(b_data);
    if (b_o_valid && b_ready) begin
      b_n++;
      if (b_q.size() == 0) chk("b_spurious_beat", 64'd1, 64'd0);
      else chk("b_data", b_o_data, b_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (c_valid && c_o_ready) c_q.push_back(c_data);
    if (c_o_valid && c_ready) begin
      c_n++;
      if (c_q.size() == 0) chk("c_spurious_beat", 64'd1, 64'd0);
      else chk("c_data", c_o_data, c_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (d_valid && d_o_ready) d_q.push_back(d_data);
    if (d_o_valid && d_ready) begin
      d_n++;
      if (d_q.size() == 0) chk("d_spurious_beat", 64'd1, 64'd0);
      else chk("d_data", d_o_data, d_q.pop_front());
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // driver
  initial begin
    logic [31:0] va [3];
    logic        hs;
    va[0] = 32'hDEADBEEF; va[1] = 32'hCAFEBABE; va[2] = 32'hFACEFEED;
    rst = 1'b1;
    {a_valid, b_valid, c_valid, d_valid} = '0;
    {a_flush, b_flush, c_flush, d_flush} = '0;
    {a_ready, b_ready, c_ready, d_ready} = '1;
    a_data = '0; b_data = '0; c_data = '0; d_data = '0;

    // reset: two cycles high, then release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_forces_o_ready_low", a_o_ready, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("a_rst_o_valid", a_o_valid, 0); chk("a_rst_occ", a_occ, 0);
    chk("a_rst_o_ready", a_o_ready, 1); chk("a_rst_o_data", a_o_data, 0);
    chk("b_rst_o_valid", b_o_valid, 0); chk("b_rst_occ", b_occ, 0);
    chk("b_rst_o_ready", b_o_ready, 1); chk("b_rst_o_data", b_o_data, 0);
    chk("c_rst_o_valid", c_o_valid, 0); chk("c_rst_occ", c_occ, 0);
    chk("c_rst_o_ready", c_o_ready, 1); chk("c_rst_o_data", c_o_data, 0);
    chk("d_rst_o_valid", d_o_valid, 0); chk("d_rst_occ", d_occ, 0);
    chk("d_rst_o_ready", d_o_ready, 1); chk("d_rst_o_data", d_o_data, 0);

    // RS_FULL depth 3: three back-to-back beats, 3-cycle latency checked by monitor
    for (int i = 0; i < 3; i++) begin
      step();
      a_valid = 1'b1;
      a_data  = va[i];
    end
    step();
    a_valid = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("a_delivered", a_n, 3);
    chk("a_occ_drained", a_occ, 0);

    // RS_FULL depth 2: downstream stalled, upstream pushing for 10 cycles
    step();
    b_ready = 1'b0;
    b_valid = 1'b1;
    b_data  = 32'h100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hs = b_o_ready;
      step();
      if (hs) b_data = b_data + 32'd1;
    end
    @(negedge clk);
    chk("b_accepted", b_data - 32'h100, 4);
    chk("b_full_o_ready", b_o_ready, 0);
    chk("b_full_occ", b_occ, 4);
    step();
    b_valid = 1'b0;
    b_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("b_delivered", b_n, 4);
    chk("b_occ_drained", b_occ, 0);

    // RS_BWD depth 1: stall captures the beat in the skid
    step();
    c_ready = 1'b0;
    c_valid = 1'b1;
    c_data  = 32'h12345678;
    @(negedge clk);
    chk("c_zero_latency_valid", c_o_valid, 1);
    chk("c_zero_latency_data", c_o_data, 32'h12345678);
    step();
    c_valid = 1'b0;
    c_data  = '0;
    @(negedge clk);
    chk("c_skid_o_ready", c_o_ready, 0);
    chk("c_skid_occ", c_occ, 1);
    chk("c_skid_data", c_o_data, 32'h12345678);
    step();
    c_ready = 1'b1;
    step();
    @(negedge clk);
    chk("c_release_o_ready", c_o_ready, 1);
    chk("c_release_occ", c_occ, 0);
    chk("c_release_delivered", c_n, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      c_valid = 1'b1;
      c_data  = 32'hA0 + i;
    end
    step();
    c_valid = 1'b0;
    @(negedge clk);
    chk("c_stream_delivered", c_n, 4);

    // RS_FWD depth 4: fill, enqueue+dequeue when full, then flush
    step();
    d_ready = 1'b0;
    d_valid = 1'b1;
    d_data  = 32'h200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hs = d_o_ready;
      step();
      if (hs) d_data = d_data + 32'd1;
    end
    @(negedge clk);
    chk("d_accepted", d_data - 32'h200, 4);
    chk("d_full_o_ready", d_o_ready, 0);
    chk("d_full_occ", d_occ, 4);
    chk("d_full_head", d_o_data, 32'h200);
    step();
    d_ready = 1'b1;
    @(negedge clk);
    chk("d_full_enq_deq_ready", d_o_ready, 1);
    step();
    d_ready = 1'b0;
    d_valid = 1'b0;
    @(negedge clk);
    chk("d_full_after_swap_occ", d_occ, 4);
    chk("d_full_after_swap_head", d_o_data, 32'h201);
    step();
    d_flush = 1'b1;
    d_valid = 1'b1;
    d_ready = 1'b1;
    d_data  = 32'h2FF;
    @(negedge clk);
    chk("d_flush_o_ready", d_o_ready, 0);
    chk("d_flush_o_valid", d_o_valid, 0);
    step();
    d_flush = 1'b0;
    d_valid = 1'b0;
    d_q.delete();
    @(negedge clk);
    chk("d_post_flush_occ", d_occ, 0);
    chk("d_post_flush_o_valid", d_o_valid, 0);
    chk("d_post_flush_o_ready", d_o_ready, 1);
    chk("d_delivered_before_flush", d_n, 1);

    // rst mid-transfer on RS_FULL depth 2
    step();
    b_ready = 1'b0;
    b_valid = 1'b1;
    b_data  = 32'h400;
    step();
    b_data  = 32'h401;
    step();
    rst     = 1'b1;
    b_ready = 1'b1;
    b_data  = 32'h402;
    @(negedge clk);
    chk("b_rst_mid_o_ready", b_o_ready, 0);
    chk("b_rst_mid_o_valid", b_o_valid, 0);
    step();
    rst     = 1'b0;
    b_valid = 1'b0;
    b_q.delete();
    @(negedge clk);
    chk("b_rst_mid_occ", b_occ, 0);
    chk("b_rst_mid_o_data", b_o_data, 0);
    chk("b_rst_mid_o_ready", b_o_ready, 1);

`ifdef RS_CHAIN_STATS_EN
    // statistics on RS_FWD depth 4: 1 beat stalled 3 cycles, then 4 streamed
    chk("d_stats_rst_xfer", d_xfer, 0);
    chk("d_stats_rst_stall", d_stall, 0);
    step();
    d_ready = 1'b0;
    d_valid = 1'b1;
    d_data  = 32'h300;
    step();
    d_valid = 1'b0;
    repeat (6) step();
    d_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      d_valid = 1'b1;
      d_data  = 32'h300 + i;
    end
    step();
    d_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("d_stats_xfer", d_xfer, 5);
    chk("d_stats_stall", d_stall, 3);
    step();
    d_flush = 1'b1;
    step();
    d_flush = 1'b0;
    @(negedge clk);
    chk("d_stats_flush_xfer", d_xfer, 5);
    chk("d_stats_flush_stall", d_stall, 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("d_stats_clear_xfer", d_xfer, 0);
    chk("d_stats_clear_stall", d_stall, 0);
`endif

    step();
    chk("a_queue_empty", a_q.size(), 0);
    chk("c_queue_empty", c_q.size(), 0);
    chk("d_queue_empty", d_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_slice_chain.md
REGISTER_SLICE_CHAIN -- requirements
Module: register_slice_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of cascaded slice stages (1..16).
REQ-003 SHALL have parameter MODE, default RS_FULL, stage type from rs_pkg: RS_FWD, RS_BWD or RS_FULL.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered beats.
REQ-007 SHALL have port i_valid  input  1  upstream beat valid.
REQ-008 SHALL have port o_ready  output  1  ready returned to upstream.
REQ-009 SHALL have port i_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port o_valid  output  1  downstream beat valid.
REQ-011 SHALL have port i_ready  input  1  ready from downstream.
REQ-012 SHALL have port o_data  output  DATA_W  downstream payload.
REQ-013 SHALL have port occupancy  output  $clog2(2*DEPTH+1)  count of beats held in the chain.

Function
REQ-014 Handshake: transfer occurs when valid&ready are both high at a rising edge; beats SHALL exit in order, never duplicated, never dropped (except by flush).
REQ-015 RS_FWD stage: 1 entry; o_valid/o_data registered; stage ready = ~full | downstream ready (combinational); latency 1 cycle per stage.
REQ-016 RS_BWD stage: 1 skid entry; stage ready registered (= skid empty); o_valid = skid full | upstream valid; latency 0 cycles; downstream stall with upstream beat in flight SHALL capture the beat into skid.
REQ-017 RS_FULL stage: 2 entries; valid, data and ready all registered; latency 1 cycle per stage; sustains 1 beat/cycle with downstream ready held high.
REQ-018 Chain latency SHALL be DEPTH cycles for RS_FWD/RS_FULL and 0 for RS_BWD, with full throughput in steady state.
REQ-019 occupancy SHALL equal the number of valid entries across all stages, updated each cycle; maximum DEPTH (FWD/BWD) or 2*DEPTH (FULL).
REQ-020 Full chain with i_ready low: o_ready SHALL be 0 and no beat lost; simultaneous enqueue and dequeue when full (FWD) SHALL be accepted.
REQ-021 Flush cycle: o_ready and o_valid forced 0 (no handshakes); all entries cleared at the edge; occupancy 0 next cycle.
REQ-022 flush and rst asserted together: rst behaviour applies.

Reset
REQ-023 On rst all entries SHALL be invalid; next cycle o_valid=0, occupancy=0, o_data=0, o_ready=1 (all modes).
REQ-024 rst asserted mid-transfer SHALL discard all in-flight beats; no handshake is honoured in a cycle with rst high (o_ready and o_valid forced 0).

Configuration
REQ-025 Macro RS_CHAIN_STATS_EN defined: ports xfer_cnt (output, 32) counting output handshakes and stall_cnt (output, 32) counting cycles with o_valid=1 & i_ready=0; both wrap at 2^32, cleared by rst only, not by flush.
REQ-026 Macro not defined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package rs_pkg SHALL hold the rs_mode_e enum (RS_FWD, RS_BWD, RS_FULL) and the DEPTH max constant RS_MAX_DEPTH=16.
REQ-028 One sub-module rs_stage (parameters DATA_W, MODE) SHALL implement a single stage; the top SHALL generate DEPTH instances and sum per-stage occupancy.

Verification
REQ-029 rst high 2 cycles, then low -> o_valid=0, occupancy=0, o_ready=1 in every mode.
REQ-030 RS_FULL, DEPTH=3, i_ready=1, push 0xDEADBEEF,0xCAFEBABE,0xFACEFEED on consecutive cycles -> same values on o_data exactly 3 cycles later, back-to-back.
REQ-031 RS_FULL, DEPTH=2, i_ready=0, i_valid=1 for 10 cycles -> 4 beats accepted, o_ready=0 after, occupancy=4; release i_ready -> 4 beats out in order.
REQ-032 RS_BWD, DEPTH=1, push 0x12345678 with i_ready=0 -> skid captures, o_ready=0 next cycle; i_ready=1 -> 0x12345678 delivered, o_ready=1.
REQ-033 RS_FWD, DEPTH=4, chain full, pulse flush -> no handshake that cycle, occupancy=0 next cycle, o_valid=0.
REQ-034 RS_CHAIN_STATS_EN: 5 beats delivered with 3 stalled cycles -> xfer_cnt=5, stall_cnt=3; flush leaves them unchanged; rst clears to 0.
